gpr_wport_arbiter: RTL

Shares the single GPR write port between the pipeline writeback stage and a multi-cycle multiply/divide unit (MDU).
- Writeback always has priority.
- The MDU uses a valid/ready handshake.
- A starvation counter forces a one-cycle pipeline stall so a waiting MDU result can retire.
- Sits between WB/MDU and the register file. Drives the register file's reg_write/num_write/data_write inputs combinationally, so register-file write timing is unchanged.

---
 rtl/gpr_wport_arbiter_pkg.sv | 16 +
 rtl/gpr_wport_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gpr_wport_arbiter_pkg.sv
// gpr_wport_arbiter_pkg
// Shared pipeline definitions used by the GPR write-port arbiter:
//   - GPR index and data widths
//   - arbiter FSM state encoding
package gpr_wport_arbiter_pkg;

  localparam int unsigned GPR_NUM_W  = 5;
  localparam int unsigned GPR_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } arb_state_e;

endpackage : gpr_wport_arbiter_pkg

// File: rtl/gpr_wport_arbiter.sv
// gpr_wport_arbiter
// Shares the single GPR write port between the writeback stage (priority)
// and the multi-cycle MDU (valid/ready). A starvation counter forces a
// one-cycle pipeline stall so a blocked MDU result can retire.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   wb_en/wb_num/wb_data      writeback write request
//   md_valid/md_num/md_data   MDU result (held stable until md_ready)
//   md_ready            MDU result accepted this cycle (combinational)
//   stall_req           pipeline must hold and present wb_en=0 (Moore)
//   reg_write/num_write/data_write  register-file write port (combinational)
//   proto_err           sticky: writeback attempted while stall_req=1
module gpr_wport_arbiter
  import gpr_wport_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [GPR_NUM_W-1:0]  wb_num,
  input  logic [GPR_DATA_W-1:0] wb_data,
  input  logic                  md_valid,
  input  logic [GPR_NUM_W-1:0]  md_num,
  input  logic [GPR_DATA_W-1:0] md_data,
  output logic                  md_ready,
  output logic                  stall_req,
  output logic                  reg_write,
  output logic [GPR_NUM_W-1:0]  num_write,
  output logic [GPR_DATA_W-1:0] data_write,
  output logic                  proto_err
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  arb_state_e            state_r;
  arb_state_e            state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  proto_err_r;
  logic                  wb_act_s;
  logic                  in_stall_s;
  logic                  wb_sel_s;

  // A write to r0 never occupies the port.
  assign wb_act_s   = wb_en & (wb_num != {GPR_NUM_W{1'b0}});
  assign in_stall_s = (state_r == ST_STALL);
  assign cnt_inc_s  = cnt_r + ONE_C;
  // Data path selects WB only when it actually owns the port.
  assign wb_sel_s   = wb_act_s & ~in_stall_s;

  // Outputs that are state-derived are masked while reset is asserted.
  assign stall_req  = in_stall_s & ~reset;
  assign proto_err  = proto_err_r & ~reset;

  // Next-state and starvation-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (md_valid && wb_act_s) begin
          cnt_nxt_s = ONE_C;
          if (STARVE_LIMIT == 1) begin
            state_nxt_s = ST_STALL;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = ZERO_C;
        end
      end
      ST_WAIT: begin
        // Dropping md_valid before grant is an MDU fault; just go idle.
        if (!md_valid || !wb_act_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = ZERO_C;
        end else if (cnt_inc_s == LIMIT_C) begin
          state_nxt_s = ST_STALL;
          cnt_nxt_s   = cnt_inc_s;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      ST_STALL: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = ZERO_C;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = ZERO_C;
      end
    endcase
  end

  // Write-port grant and register-file mux.
  always_comb begin
    md_ready   = 1'b0;
    reg_write  = 1'b0;
    num_write  = md_num;
    data_write = md_data;
    if (wb_sel_s) begin
      num_write  = wb_num;
      data_write = wb_data;
    end else begin
      num_write  = md_num;
      data_write = md_data;
    end
    if (reset) begin
      md_ready  = 1'b0;
      reg_write = 1'b0;
    end else if (in_stall_s) begin
      // MDU owns the port; any concurrent WB write is dropped.
      md_ready  = md_valid;
      reg_write = md_valid & (md_num != {GPR_NUM_W{1'b0}});
    end else if (wb_act_s) begin
      md_ready  = 1'b0;
      reg_write = 1'b1;
    end else if (md_valid) begin
      // r0 result still completes the handshake but writes nothing.
      md_ready  = 1'b1;
      reg_write = (md_num != {GPR_NUM_W{1'b0}});
    end else begin
      md_ready  = 1'b0;
      reg_write = 1'b0;
    end
  end

  // State, counter and sticky protocol-error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= ZERO_C;
      proto_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (in_stall_s && wb_act_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

endmodule : gpr_wport_arbiter
